// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and data requesters; data
//            has priority, reads are sequenced over MEM_LAT cycles.
//            Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        fetch_stall,
    output logic        mem_stall
);

    localparam logic       c_STATE_IDLE    = 1'b0;
    localparam logic       c_STATE_RD_WAIT = 1'b1;
    localparam logic [2:0] c_LAT_M1        = 3'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 8 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_badParams
            $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
        end
    endgenerate

    logic        r_state;
    logic [2:0]  r_cnt;
    logic        r_ownerDm;
    logic        r_ifValid;
    logic        r_dmValid;
    logic [15:0] r_ifRdata;
    logic [15:0] r_dmRdata;

    logic w_idle, w_ifElig, w_dmElig, w_forceIf;
    logic w_grantDm, w_grantIf, w_grantRead, w_capture, w_capDm;

    // A requester is masked during its own valid cycle so a held req restarts cleanly.
    assign w_ifElig    = if_req & ~r_ifValid;
    assign w_dmElig    = dm_req & ~r_dmValid;
    assign w_idle      = (r_state == c_STATE_IDLE) & ~reset;
    assign w_grantDm   = w_idle & w_dmElig & ~w_forceIf;
    assign w_grantIf   = w_idle & w_ifElig & ~w_grantDm;
    assign w_grantRead = w_grantIf | (w_grantDm & ~dm_we);

    // Single-cycle latency captures in the grant cycle; longer ones on the last wait cycle.
    assign w_capture = ((r_state == c_STATE_IDLE) & w_grantRead & (MEM_LAT == 1)) |
                       ((r_state == c_STATE_RD_WAIT) & (r_cnt == 3'd1));
    assign w_capDm   = (r_state == c_STATE_IDLE) ? w_grantDm : r_ownerDm;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    logic [3:0] r_starve;

    assign w_forceIf = (r_starve == c_STARVE_MAX) & w_ifElig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (w_grantIf || !if_req) begin
            r_starve <= 4'd0;
        end else if (w_grantDm && w_ifElig) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`else
    assign w_forceIf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_STATE_IDLE;
            r_cnt     <= 3'd0;
            r_ownerDm <= 1'b0;
            r_ifValid <= 1'b0;
            r_dmValid <= 1'b0;
            r_ifRdata <= 16'h0;
            r_dmRdata <= 16'h0;
        end else begin
            r_ifValid <= 1'b0;
            r_dmValid <= 1'b0;
            case (r_state)
                c_STATE_IDLE: begin
                    if (w_grantDm && dm_we) begin
                        r_dmValid <= 1'b1;
                    end else if (w_grantRead) begin
                        r_ownerDm <= w_grantDm;
                        r_cnt     <= c_LAT_M1;
                        if (MEM_LAT != 1) begin
                            r_state <= c_STATE_RD_WAIT;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= c_STATE_IDLE;
                    end
                end
            endcase
            if (w_capture) begin
                if (w_capDm) begin
                    r_dmRdata <= mem_rdata;
                    r_dmValid <= 1'b1;
                end else begin
                    r_ifRdata <= mem_rdata;
                    r_ifValid <= 1'b1;
                end
            end
        end
    end

    assign mem_en      = w_grantDm | w_grantIf;
    assign mem_we      = w_grantDm & dm_we;
    assign mem_addr    = w_grantDm ? dm_addr : (w_grantIf ? if_addr : 16'h0);
    assign mem_wdata   = mem_we ? dm_wdata : 16'h0;

    assign if_valid    = r_ifValid;
    assign if_rdata    = r_ifRdata;
    assign dm_valid    = r_dmValid;
    assign dm_rdata    = r_dmRdata;
    assign fetch_stall = if_req & ~r_ifValid;
    assign mem_stall   = dm_req & ~r_dmValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized requesters and memory checked against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_valid, dm_valid, mem_en, mem_we, fetch_stall, mem_stall;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_stall(fetch_stall), .mem_stall(mem_stall)
    );

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nTests++;
        if (obs !== expv) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, obs, expv);
        end
    endtask

    // Memory contents seen by reads: a fixed scramble of the address.
    function automatic logic [15:0] memFn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Reference model: one outstanding read with its due cycle, pending valids, rdata.
    bit          mIfV, mDmV, mPend, mPendDm;
    logic [15:0] mIfRd, mDmRd, mPendAddr;
    int          mPendDue, mStarve;

    // Requester state
    bit          ifAct, dmAct, dmW;
    logic [15:0] ifA, dmA, dmWd;

    task automatic modelReset();
        mIfV = 0; mDmV = 0; mPend = 0; mPendDm = 0;
        mIfRd = 16'h0; mDmRd = 16'h0; mPendAddr = 16'h0;
        mPendDue = -1; mStarve = 0;
    endtask

    task automatic doCycle(input bit rst, input int pIf, input int pDm, input int pStore);
        bit idle, ifE, dmE, forceIf, gDm, gIf, nIfV, nDmV;
        logic [15:0] expAddr;
        @(posedge clk);
        #1;
        if (ifAct && mIfV) ifAct = ($urandom_range(3) == 0);
        if (dmAct && mDmV) dmAct = ($urandom_range(3) == 0);
        if (!ifAct && int'($urandom_range(99)) < pIf) begin
            ifAct = 1; ifA = 16'($urandom);
        end
        if (!dmAct && int'($urandom_range(99)) < pDm) begin
            dmAct = 1; dmA = 16'($urandom); dmWd = 16'($urandom);
            dmW = (int'($urandom_range(99)) < pStore);
        end
        reset    = rst;
        if_req   = ifAct;
        if_addr  = ifAct ? ifA : 16'($urandom);
        dm_req   = dmAct;
        dm_we    = dmAct ? dmW : 1'($urandom);
        dm_addr  = dmAct ? dmA : 16'($urandom);
        dm_wdata = dmAct ? dmWd : 16'($urandom);

        idle    = !mPend && !rst;
        ifE     = ifAct && !mIfV;
        dmE     = dmAct && !mDmV;
        forceIf = GUARD && (mStarve == STARVE_MAX) && ifE;
        gDm     = idle && dmE && !forceIf;
        gIf     = idle && ifE && !gDm;
        expAddr = gDm ? dmA : (gIf ? ifA : 16'h0);
        if (gIf || (gDm && !dmW)) begin
            mPend = 1; mPendDm = gDm; mPendAddr = expAddr;
            mPendDue = cyc + MEM_LAT - 1;
        end
        mem_rdata = (mPend && mPendDue == cyc && !rst) ? memFn(mPendAddr) : 16'($urandom);

        @(negedge clk);
        check("if_valid",    16'(if_valid),    16'(mIfV));
        check("dm_valid",    16'(dm_valid),    16'(mDmV));
        check("if_rdata",    if_rdata,         mIfRd);
        check("dm_rdata",    dm_rdata,         mDmRd);
        check("mem_en",      16'(mem_en),      16'(gDm || gIf));
        check("mem_we",      16'(mem_we),      16'(gDm && dmW));
        check("mem_addr",    mem_addr,         expAddr);
        check("mem_wdata",   mem_wdata,        (gDm && dmW) ? dmWd : 16'h0);
        check("fetch_stall", 16'(fetch_stall), 16'(ifAct && !mIfV));
        check("mem_stall",   16'(mem_stall),   16'(dmAct && !mDmV));

        if (rst) begin
            modelReset();
        end else begin
            nIfV = 0; nDmV = 0;
            if (gDm && dmW) nDmV = 1;
            if (mPend && mPendDue == cyc) begin
                if (mPendDm) begin mDmRd = memFn(mPendAddr); nDmV = 1; end
                else         begin mIfRd = memFn(mPendAddr); nIfV = 1; end
                mPend = 0;
            end
            if (GUARD) begin
                if (gIf || !ifAct)     mStarve = 0;
                else if (gDm && ifE)   mStarve++;
            end
            mIfV = nIfV; mDmV = nDmV;
        end
        cyc++;
    endtask

    initial begin
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
        ifAct = 0; dmAct = 0; dmW = 0; ifA = 16'h0; dmA = 16'h0; dmWd = 16'h0;
        modelReset();
        repeat (2) @(posedge clk);
        doCycle(1, 0, 0, 0);
        repeat (5) doCycle(0, 0, 0, 0);
        // Moderate traffic with occasional reset landing mid-read
        for (int i = 0; i < 1500; i++)
            doCycle($urandom_range(99) == 0, 30, 40, 40);
        // Heavy contention: both requesters nearly always asking
        for (int i = 0; i < 1000; i++)
            doCycle($urandom_range(199) == 0, 90, 95, 25);
        // Store-heavy burst
        for (int i = 0; i < 400; i++)
            doCycle(1'b0, 60, 95, 90);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
